word_plotter: RTL and testbench

WORD_PLOTTER -- requirements
Module: word_plotter

---
 rtl/word_plotter.sv | 164 ++++++++++++++++
 tb/tb_word_plotter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_plotter.sv
// Word plotter: sequences a character drawer across a word, offsets its pixels
// into screen space, clips them to the visible area and counts what was plotted.
module word_plotter #(
    parameter int CHAR_PITCH = 8,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int TIMEOUT    = 80
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [3:0] char_count,
    input  logic       delete,
    output logic       busy,
    output logic       word_done,
    output logic       timeout_err,
    output logic       char_go,
    output logic       char_delete,
    output logic [3:0] char_index,
    input  logic [2:0] rel_x,
    input  logic [2:0] rel_y,
    input  logic [2:0] rel_colour,
    input  logic       char_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic [9:0] plot_count
);

    typedef enum logic [2:0] {IDLE, GO, STREAM, NEXT, FINISH} state_t;

    localparam int             TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]     XLIM  = 9'(SCREEN_W);
    localparam logic [8:0]     YLIM  = 9'(SCREEN_H);

    state_t        r_state;
    logic [7:0]    r_base_x;
    logic [6:0]    r_base_y;
    logic [3:0]    r_count;
    logic          r_delete;
    logic [3:0]    r_index;
    logic [TW-1:0] r_timer;
    logic          r_char_go;
    logic          r_word_done;
    logic          r_timeout;
    logic          r_plot;
    logic [7:0]    r_vga_x;
    logic [6:0]    r_vga_y;
    logic [2:0]    r_vga_colour;
    logic [9:0]    r_plot_count;

    logic [8:0]    w_char_off;
    logic [8:0]    w_ax;
    logic [8:0]    w_ay;
    logic          w_in_view;
    logic [3:0]    w_next_index;

    // 9-bit arithmetic so pixels past the right/bottom edge are clipped, not wrapped
    assign w_char_off   = 9'(int'(r_index) * CHAR_PITCH);
    assign w_ax         = {1'b0, r_base_x} + w_char_off + {6'b0, rel_x};
    assign w_ay         = {2'b0, r_base_y} + {6'b0, rel_y};
    assign w_in_view    = (w_ax < XLIM) && (w_ay < YLIM);
    assign w_next_index = r_index + 4'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_base_x     <= '0;
            r_base_y     <= '0;
            r_count      <= '0;
            r_delete     <= 1'b0;
            r_index      <= '0;
            r_timer      <= '0;
            r_char_go    <= 1'b0;
            r_word_done  <= 1'b0;
            r_timeout    <= 1'b0;
            r_plot       <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_plot_count <= '0;
        end else begin
            r_char_go   <= 1'b0;
            r_word_done <= 1'b0;
            r_plot      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_base_x     <= base_x;
                        r_base_y     <= base_y;
                        r_count      <= char_count;
                        r_delete     <= delete;
                        r_index      <= '0;
                        r_plot_count <= '0;
                        r_timeout    <= 1'b0;
                        if (char_count == 4'd0) begin
                            r_state <= FINISH;
                        end else begin
                            r_state   <= GO;
                            r_char_go <= 1'b1;
                        end
                    end
                end
                GO: begin
                    r_timer <= '0;
                    r_state <= STREAM;
                end
                STREAM: begin
                    // a drawer that finishes on its last allowed cycle is not a timeout
                    if (char_done) begin
                        r_state <= NEXT;
                    end else begin
                        if (w_in_view) begin
                            r_plot       <= 1'b1;
                            r_vga_x      <= w_ax[7:0];
                            r_vga_y      <= w_ay[6:0];
                            r_vga_colour <= r_delete ? 3'b000 : rel_colour;
                            if (r_plot_count != 10'h3FF) begin
                                r_plot_count <= r_plot_count + 10'd1;
                            end
                        end
                        if (r_timer == TLAST) begin
                            r_timeout <= 1'b1;
                            r_state   <= FINISH;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    r_index <= w_next_index;
                    if (w_next_index == r_count) begin
                        r_state <= FINISH;
                    end else begin
                        r_state   <= GO;
                        r_char_go <= 1'b1;
                    end
                end
                FINISH: begin
                    r_word_done <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign word_done   = r_word_done;
    assign timeout_err = r_timeout;
    assign char_go     = r_char_go;
    assign char_delete = r_delete;
    assign char_index  = r_index;
    assign vga_x       = r_vga_x;
    assign vga_y       = r_vga_y;
    assign vga_colour  = r_vga_colour;
    assign plot        = r_plot;
    assign plot_count  = r_plot_count;

endmodule

// File: tb/tb_word_plotter.sv
// Bench for word_plotter: a drawer model feeds pixels and a screen-space model
// predicts every strobe, which is compared against what the plotter emits.
module tb_word_plotter;

    localparam int PITCH = 8;
    localparam int SW    = 160;
    localparam int SH    = 120;
    localparam int TMO   = 80;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req = 1'b0;
    logic [7:0] base_x = '0;
    logic [6:0] base_y = '0;
    logic [3:0] char_count = '0;
    logic       delete = 1'b0;
    logic [2:0] rel_x = '0;
    logic [2:0] rel_y = '0;
    logic [2:0] rel_colour = '0;
    logic       char_done = 1'b1;
    logic       busy, word_done, timeout_err, char_go, char_delete, plot;
    logic [3:0] char_index;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic [9:0] plot_count;

    word_plotter #(.CHAR_PITCH(PITCH), .SCREEN_W(SW), .SCREEN_H(SH), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .req(req), .base_x(base_x), .base_y(base_y),
        .char_count(char_count), .delete(delete), .busy(busy), .word_done(word_done),
        .timeout_err(timeout_err), .char_go(char_go), .char_delete(char_delete),
        .char_index(char_index), .rel_x(rel_x), .rel_y(rel_y), .rel_colour(rel_colour),
        .char_done(char_done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .plot_count(plot_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] expPix[$];
    logic [17:0] obsPix[$];
    int          goCount, firstGo, timeoutRise, doneCycle;
    bit          busyDropped;

    // index of the first differing pixel, or -1 when both lists agree
    function automatic int pixDiff();
        int n;
        n = (expPix.size() < obsPix.size()) ? expPix.size() : obsPix.size();
        for (int i = 0; i < n; i++) if (obsPix[i] !== expPix[i]) return i;
        if (expPix.size() != obsPix.size()) return n;
        return -1;
    endfunction

    // Drives one word and plays the drawer; mode 0 = 8x8 white grid, 1 = random pixels
    task automatic run_word(input logic [7:0] bx, input logic [6:0] by, input logic [3:0] cnt,
                            input logic del, input int npix, input int mode,
                            input int abortAt, input bit scramble);
        bit         active;
        int         pixIdx, ci, ax, ay;
        logic [2:0] rx, ry, rc;
        expPix.delete(); obsPix.delete();
        goCount = 0; firstGo = -1; timeoutRise = -1; doneCycle = -1; busyDropped = 0;
        active = 0; pixIdx = 0; ci = -1;
        base_x = bx; base_y = by; char_count = cnt; delete = del; char_done = 1'b1;
        req = 1'b1;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            @(posedge clk); #1;
            if (abortAt != 0 && cyc == abortAt) begin req = 1'b0; return; end
            if (plot) obsPix.push_back({vga_x, vga_y, vga_colour});
            if (timeout_err && timeoutRise < 0) timeoutRise = cyc;
            if (word_done) begin doneCycle = cyc; req = 1'b0; return; end
            if (!busy) busyDropped = 1;
            req = scramble;
            if (scramble) begin
                base_x = 8'($urandom); base_y = 7'($urandom);
                char_count = 4'($urandom); delete = 1'($urandom);
            end
            if (active) begin
                if (pixIdx < npix) begin
                    if (mode == 0) begin
                        rx = 3'(pixIdx % 8); ry = 3'(pixIdx / 8); rc = 3'b111;
                    end else begin
                        rx = 3'($urandom); ry = 3'($urandom); rc = 3'($urandom);
                    end
                    rel_x = rx; rel_y = ry; rel_colour = rc; char_done = 1'b0;
                    ax = int'(bx) + ci * PITCH + int'(rx);
                    ay = int'(by) + int'(ry);
                    if (ax < SW && ay < SH) expPix.push_back({8'(ax), 7'(ay), del ? 3'b000 : rc});
                    pixIdx++;
                end else begin
                    char_done = 1'b1; active = 0;
                end
            end
            if (char_go) begin
                goCount++; ci++; active = 1; pixIdx = 0; char_done = 1'b0;
                if (firstGo < 0) firstGo = cyc;
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, word_done, timeout_err, char_go, char_delete, char_index, vga_x, vga_y,
             vga_colour, plot, plot_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: busy=%b done=%b to=%b go=%b del=%b idx=%0d x=%0d y=%0d col=%0d plot=%b cnt=%0d, want all 0",
                     busy, word_done, timeout_err, char_go, char_delete, char_index, vga_x, vga_y,
                     vga_colour, plot, plot_count);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_word();
        int d, xmin, xmax, ymin, ymax;
        run_word(8'd10, 7'd20, 4'd2, 1'b0, 64, 0, 0, 0);
        checks++; if (doneCycle < 0) begin errors++; $display("[TB] FAIL basic_done: no word_done, want one"); end
        d = pixDiff();
        checks++; if (d != -1) begin errors++; $display("[TB] FAIL basic_pixels: first diff at %0d, got %0d plots want %0d", d, obsPix.size(), expPix.size()); end
        checks++; if (plot_count !== 10'd128) begin errors++; $display("[TB] FAIL basic_count: got %0d want 128", plot_count); end
        xmin = 999; xmax = -1; ymin = 999; ymax = -1;
        foreach (obsPix[i]) begin
            if (int'(obsPix[i][17:10]) < xmin) xmin = int'(obsPix[i][17:10]);
            if (int'(obsPix[i][17:10]) > xmax) xmax = int'(obsPix[i][17:10]);
            if (int'(obsPix[i][9:3]) < ymin) ymin = int'(obsPix[i][9:3]);
            if (int'(obsPix[i][9:3]) > ymax) ymax = int'(obsPix[i][9:3]);
        end
        checks++; if (xmin != 10 || xmax != 25) begin errors++; $display("[TB] FAIL basic_xspan: got %0d..%0d want 10..25", xmin, xmax); end
        checks++; if (ymin != 20 || ymax != 27) begin errors++; $display("[TB] FAIL basic_yspan: got %0d..%0d want 20..27", ymin, ymax); end
        checks++; if (goCount != 2 || busyDropped) begin errors++; $display("[TB] FAIL basic_seq: go=%0d busyDropped=%0d want 2/0", goCount, busyDropped); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (word_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b want 0", word_done); end
    endtask

    task automatic test_right_clip();
        int d;
        run_word(8'd155, 7'd30, 4'd1, 1'b0, 64, 0, 0, 0);
        d = pixDiff();
        checks++; if (d != -1 || doneCycle < 0) begin errors++; $display("[TB] FAIL clip_pixels: diff at %0d done=%0d, got %0d plots want %0d", d, doneCycle, obsPix.size(), expPix.size()); end
        checks++; if (plot_count !== 10'd40) begin errors++; $display("[TB] FAIL clip_count: got %0d want 40", plot_count); end
        foreach (obsPix[i]) begin
            checks++;
            if (obsPix[i][17:10] < 8'd155 || obsPix[i][17:10] > 8'd159) begin
                errors++; $display("[TB] FAIL clip_x: got %0d want 155..159", obsPix[i][17:10]);
            end
        end
    endtask

    task automatic test_zero_count();
        run_word(8'd50, 7'd50, 4'd0, 1'b0, 64, 1, 0, 0);
        checks++; if (doneCycle != 2) begin errors++; $display("[TB] FAIL zero_latency: got %0d want 2", doneCycle); end
        checks++; if (goCount != 0 || obsPix.size() != 0) begin errors++; $display("[TB] FAIL zero_activity: go=%0d plots=%0d want 0/0", goCount, obsPix.size()); end
        checks++; if (plot_count !== 10'd0) begin errors++; $display("[TB] FAIL zero_count: got %0d want 0", plot_count); end
    endtask

    task automatic test_delete();
        int d;
        run_word(8'd40, 7'd50, 4'd3, 1'b1, 64, 0, 0, 0);
        d = pixDiff();
        checks++; if (d != -1 || doneCycle < 0) begin errors++; $display("[TB] FAIL delete_pixels: diff at %0d done=%0d", d, doneCycle); end
        foreach (obsPix[i]) begin
            checks++;
            if (obsPix[i][2:0] !== 3'b000) begin errors++; $display("[TB] FAIL delete_colour: got %0d want 0", obsPix[i][2:0]); end
        end
        checks++; if (plot_count !== 10'd192) begin errors++; $display("[TB] FAIL delete_count: got %0d want 192", plot_count); end
    endtask

    task automatic test_timeout();
        int lat;
        run_word(8'd30, 7'd127, 4'd1, 1'b0, 1000, 1, 0, 0);
        lat = timeoutRise - firstGo;
        checks++; if (doneCycle < 0 || timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: done=%0d err=%b want done and 1", doneCycle, timeout_err); end
        checks++; if (timeoutRise < 0 || lat < TMO || lat > TMO + 1) begin errors++; $display("[TB] FAIL timeout_latency: got %0d want %0d..%0d", lat, TMO, TMO + 1); end
        checks++; if (doneCycle != timeoutRise + 1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_finish: done=%0d rise=%0d busy=%b", doneCycle, timeoutRise, busy); end
        checks++; if (plot_count !== 10'd0 || goCount != 1) begin errors++; $display("[TB] FAIL timeout_activity: cnt=%0d go=%0d want 0/1", plot_count, goCount); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int d;
        run_word(8'd0, 7'd0, 4'd4, 1'b0, 64, 1, 30, 0);
        checks++; if (busy !== 1'b1 || plot_count == 10'd0) begin errors++; $display("[TB] FAIL midreset_pre: busy=%b cnt=%0d want 1/nonzero", busy, plot_count); end
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || plot_count !== 10'd0 || char_index !== 4'd0) begin
            errors++; $display("[TB] FAIL midreset_clear: plot=%b busy=%b cnt=%0d idx=%0d want 0", plot, busy, plot_count, char_index);
        end
        resetn = 1'b1;
        char_done = 1'b1;
        @(posedge clk); #1;
        run_word(8'd5, 7'd5, 4'd2, 1'b0, 64, 1, 0, 0);
        d = pixDiff();
        checks++; if (d != -1 || doneCycle < 0 || plot_count !== 10'(expPix.size())) begin
            errors++; $display("[TB] FAIL midreset_after: diff=%0d done=%0d cnt=%0d want %0d", d, doneCycle, plot_count, expPix.size());
        end
    endtask

    task automatic test_saturation();
        run_word(8'd0, 7'd0, 4'd15, 1'b0, 70, 1, 0, 0);
        checks++; if (expPix.size() != 1050 || obsPix.size() != 1050) begin errors++; $display("[TB] FAIL sat_strobes: got %0d want 1050", obsPix.size()); end
        checks++; if (plot_count !== 10'd1023) begin errors++; $display("[TB] FAIL sat_count: got %0d want 1023", plot_count); end
    endtask

    task automatic test_back_to_back();
        int d, npix, expCnt;
        logic [3:0] cnt;
        for (int w = 0; w < 6; w++) begin
            cnt = 4'($urandom_range(1, 15));
            npix = $urandom_range(0, 70);
            run_word(8'($urandom), 7'($urandom), cnt, 1'($urandom), npix, 1, 0, (w % 2) == 1);
            d = pixDiff();
            expCnt = (expPix.size() > 1023) ? 1023 : expPix.size();
            checks++; if (d != -1 || doneCycle < 0) begin errors++; $display("[TB] FAIL b2b_pixels[%0d]: diff=%0d done=%0d", w, d, doneCycle); end
            checks++; if (plot_count !== 10'(expCnt) || goCount != int'(cnt)) begin
                errors++; $display("[TB] FAIL b2b_count[%0d]: cnt=%0d go=%0d want %0d/%0d", w, plot_count, goCount, expCnt, cnt);
            end
            checks++; if (timeout_err !== 1'b0 || busyDropped) begin errors++; $display("[TB] FAIL b2b_flags[%0d]: to=%b busyDropped=%0d want 0/0", w, timeout_err, busyDropped); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_right_clip();
        test_zero_count();
        test_delete();
        test_timeout();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
